t5_hsched: RTL and testbench

- Hart scheduler and fetch-PC sequencer for the four-hart barrel-threaded T5 core.
- Keeps one architectural fetch PC per hart and a per-hart run state.
- Each enabled cycle it picks the next runnable hart round-robin and presents fpc to the fetch stage, with the hart id in fpc[1:0]. This feeds the decode stage's fpc input.
- Applies execute-stage redirects per hart, and handles wake, sleep, block and resume requests per hart.

---
 rtl/t5_hsched.sv | 157 +++++++++++++++
 tb/tb_t5_hsched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/t5_hsched.sv
// Four-hart barrel scheduler: per-hart run state + fetch PC, round-robin issue onto fpc.
// One cycle from request/redirect to fpc; sena low stalls issue only, state/PC events still apply.
module t5_hsched #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] WAKE_VEC  = XLEN'(32'h0000_0100)
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic [3:0]      hwake,
    input  logic [3:0]      hsleep,
    input  logic [3:0]      hblk,
    input  logic [3:0]      hrsm,
    input  logic            xbra,
    input  logic [1:0]      xhart,
    input  logic [XLEN-1:0] xtgt,
    output logic [XLEN-1:0] fpc,
    output logic            fvld,
    output logic [7:0]      hstat
);

    typedef enum logic [1:0] {
        OFF = 2'b00,
        RUN = 2'b01,
        BLK = 2'b10
    } hst_t;

    localparam logic [XLEN-1:0] RST_PC  = {RESET_VEC[XLEN-1:2], 2'b00};
    localparam logic [XLEN-1:0] WAKE_PC = {WAKE_VEC[XLEN-1:2], 2'b00};
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);

    hst_t            st_q [4];
    hst_t            st_d [4];
    logic [XLEN-1:0] pc_q [4];
    logic [XLEN-1:0] pc_d [4];

    logic [1:0]      rptr;
    logic [XLEN-1:0] fpc_q;
    logic            fvld_q;

    logic [3:0]      elig;
    logic [3:0]      redir;
    logic [1:0]      sel;
    logic            sel_vld;
    logic            issue;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] base;

    assign tgt = {xtgt[XLEN-1:2], 2'b00};

    // Eligibility and redirect qualification use registered state masked by this cycle's requests.
    always_comb begin
        elig  = '0;
        redir = '0;
        for (int h = 0; h < 4; h++) begin
            elig[h]  = (st_q[h] == RUN) && !hsleep[h] && !hblk[h];
            redir[h] = xbra && (xhart == 2'(h)) && (st_q[h] != OFF) && !hsleep[h];
        end
    end

    always_comb begin : arb
        logic [1:0] cand;
        cand    = '0;
        sel     = '0;
        sel_vld = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = rptr + 2'(k);
            if (!sel_vld && elig[cand]) begin
                sel     = cand;
                sel_vld = 1'b1;
            end
        end
    end

    assign issue = sena && sel_vld;
    // A redirect to the hart being issued bypasses straight onto fpc.
    assign base  = redir[sel] ? tgt : pc_q[sel];

    always_comb begin
        for (int h = 0; h < 4; h++) begin
            st_d[h] = st_q[h];
            case (st_q[h])
                OFF: begin
                    if (hwake[h] && !hsleep[h]) begin
                        st_d[h] = RUN;
                    end
                end
                RUN: begin
                    if (hsleep[h]) begin
                        st_d[h] = OFF;
                    end else if (redir[h]) begin
                        st_d[h] = RUN;
                    end else if (hblk[h]) begin
                        st_d[h] = BLK;
                    end
                end
                BLK: begin
                    if (hsleep[h]) begin
                        st_d[h] = OFF;
                    end else if (redir[h] || hrsm[h]) begin
                        st_d[h] = RUN;
                    end
                end
                default: st_d[h] = OFF;
            endcase
        end
    end

    always_comb begin
        for (int h = 0; h < 4; h++) begin
            pc_d[h] = pc_q[h];
            if ((st_q[h] == OFF) && hwake[h] && !hsleep[h]) begin
                pc_d[h] = WAKE_PC;
            end else if (issue && (sel == 2'(h))) begin
                pc_d[h] = base + STEP;
            end else if (redir[h]) begin
                pc_d[h] = tgt;
            end
        end
    end

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            for (int h = 0; h < 4; h++) begin
                st_q[h] <= (h == 0) ? RUN : OFF;
                pc_q[h] <= RST_PC;
            end
        end else begin
            for (int h = 0; h < 4; h++) begin
                st_q[h] <= st_d[h];
                pc_q[h] <= pc_d[h];
            end
        end
    end

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            rptr   <= 2'd3;
            fpc_q  <= RST_PC;
            fvld_q <= 1'b0;
        end else if (sena) begin
            if (sel_vld) begin
                fpc_q  <= {base[XLEN-1:2], sel};
                fvld_q <= 1'b1;
                rptr   <= sel;
            end else begin
                fvld_q <= 1'b0;
            end
        end
    end

    assign fpc   = fpc_q;
    assign fvld  = fvld_q;
    assign hstat = {st_q[3], st_q[2], st_q[1], st_q[0]};

endmodule

// File: tb/tb_t5_hsched.sv
// Directed scenario walk-through followed by randomized traffic against a behavioural model.
module tb_t5_hsched;

    logic        sclk = 1'b0;
    logic        srst;
    logic        sena;
    logic [3:0]  hwake, hsleep, hblk, hrsm;
    logic        xbra;
    logic [1:0]  xhart;
    logic [31:0] xtgt;
    logic [31:0] fpc;
    logic        fvld;
    logic [7:0]  hstat;

    int total = 0;
    int bad   = 0;

    // Model: state codes OFF=0 RUN=1 BLK=2, one PC per hart, last issued hart.
    int          mst [4];
    logic [31:0] mpc [4];
    logic [31:0] mfpc;
    logic        mfvld;
    int          mlast;

    t5_hsched #(.XLEN(32), .RESET_VEC(32'h0), .WAKE_VEC(32'h100)) dut (
        .sclk(sclk), .srst(srst), .sena(sena),
        .hwake(hwake), .hsleep(hsleep), .hblk(hblk), .hrsm(hrsm),
        .xbra(xbra), .xhart(xhart), .xtgt(xtgt),
        .fpc(fpc), .fvld(fvld), .hstat(hstat)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic clr();
        hwake = '0; hsleep = '0; hblk = '0; hrsm = '0;
        xbra = 1'b0; xhart = '0; xtgt = '0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] e_fpc,
                              input logic e_fvld, input logic [7:0] e_hstat);
        chk({tag, ".fpc"},   fpc,          e_fpc);
        chk({tag, ".fvld"},  32'(fvld),    32'(e_fvld));
        chk({tag, ".hstat"}, 32'(hstat),   32'(e_hstat));
    endtask

    function automatic void model_reset();
        for (int h = 0; h < 4; h++) begin
            mst[h] = (h == 0) ? 1 : 0;
            mpc[h] = 32'h0;
        end
        mfpc  = 32'h0;
        mfvld = 1'b0;
        mlast = 3;
    endfunction

    // One clock edge of the scheduler rules, using the currently driven inputs.
    function automatic void model_step();
        bit          ok [4];
        bit          rd [4];
        int          nst [4];
        logic [31:0] npc [4];
        logic [31:0] t;
        int          pick;
        t = {xtgt[31:2], 2'b00};
        for (int h = 0; h < 4; h++) begin
            ok[h]  = (mst[h] == 1) && !hsleep[h] && !hblk[h];
            rd[h]  = xbra && (int'(xhart) == h) && (mst[h] != 0) && !hsleep[h];
            npc[h] = mpc[h];
            nst[h] = mst[h];
            if (mst[h] == 0 && hwake[h] && !hsleep[h]) npc[h] = 32'h100;
            else if (rd[h]) npc[h] = t;
            if (hsleep[h]) nst[h] = 0;
            else if (mst[h] == 0 && hwake[h]) nst[h] = 1;
            else if (mst[h] == 1 && !rd[h] && hblk[h]) nst[h] = 2;
            else if (mst[h] == 2 && (rd[h] || hrsm[h])) nst[h] = 1;
        end
        if (sena) begin
            pick = -1;
            for (int k = 1; k <= 4; k++)
                if (pick < 0 && ok[(mlast + k) % 4]) pick = (mlast + k) % 4;
            if (pick >= 0) begin
                logic [31:0] b;
                b = rd[pick] ? t : mpc[pick];
                mfpc      = b + 32'(pick);
                npc[pick] = b + 32'd4;
                mfvld     = 1'b1;
                mlast     = pick;
            end else begin
                mfvld = 1'b0;
            end
        end
        for (int h = 0; h < 4; h++) begin
            mst[h] = nst[h];
            mpc[h] = npc[h];
        end
    endfunction

    function automatic logic [7:0] model_hstat();
        logic [7:0] s;
        for (int h = 0; h < 4; h++) s[2*h +: 2] = 2'(mst[h]);
        return s;
    endfunction

    initial begin
        clr();
        sena = 1'b0;
        srst = 1'b1;
        #12;
        srst = 1'b0;
        #1;
        expect_out("reset", 32'h0, 1'b0, 8'h01);

        // Lone hart 0 issues every cycle.
        sena = 1'b1;
        step(); expect_out("t1.e0", 32'h0, 1'b1, 8'h01);
        step(); expect_out("t1.e1", 32'h4, 1'b1, 8'h01);
        step(); expect_out("t1.e2", 32'h8, 1'b1, 8'h01);
        #3 srst = 1'b1;
        #1 expect_out("t1.async_rst", 32'h0, 1'b0, 8'h01);
        #1 srst = 1'b0;

        // Wake harts 1-3 while stalled, then round robin.
        sena = 1'b0; hwake = 4'b1110;
        step(); clr(); expect_out("t2.wake", 32'h0, 1'b0, 8'h55);
        sena = 1'b1;
        step(); expect_out("t2.h0", 32'h000, 1'b1, 8'h55);
        step(); expect_out("t2.h1", 32'h101, 1'b1, 8'h55);
        step(); expect_out("t2.h2", 32'h102, 1'b1, 8'h55);
        step(); expect_out("t2.h3", 32'h103, 1'b1, 8'h55);
        step(); expect_out("t2.h0b", 32'h004, 1'b1, 8'h55);

        // Redirect bypass on hart 2.
        step(); expect_out("t3.h1", 32'h105, 1'b1, 8'h55);
        xbra = 1'b1; xhart = 2'd2; xtgt = 32'h2000;
        step(); clr(); expect_out("t3.byp", 32'h2002, 1'b1, 8'h55);
        step(); expect_out("t3.h3", 32'h107, 1'b1, 8'h55);
        step(); expect_out("t3.h0", 32'h008, 1'b1, 8'h55);
        step(); expect_out("t3.h1b", 32'h109, 1'b1, 8'h55);
        step(); expect_out("t3.h2next", 32'h2006, 1'b1, 8'h55);

        // Block hart 1, then resume it.
        hblk = 4'b0010;
        step(); clr(); expect_out("t4.blk", 32'h10B, 1'b1, 8'h59);
        step(); expect_out("t4.h0", 32'h00C, 1'b1, 8'h59);
        step(); expect_out("t4.h2", 32'h200A, 1'b1, 8'h59);
        step(); expect_out("t4.h3", 32'h10F, 1'b1, 8'h59);
        step(); expect_out("t4.h0b", 32'h010, 1'b1, 8'h59);
        hrsm = 4'b0010;
        step(); clr(); expect_out("t4.rsm", 32'h200E, 1'b1, 8'h55);
        step(); expect_out("t4.h3b", 32'h113, 1'b1, 8'h55);
        step(); expect_out("t4.h0c", 32'h014, 1'b1, 8'h55);
        step(); expect_out("t4.h1back", 32'h10D, 1'b1, 8'h55);

        // Sleep beats a same-cycle redirect; then everything asleep.
        hsleep = 4'b0001; xbra = 1'b1; xhart = 2'd0; xtgt = 32'h3000;
        step(); clr(); expect_out("t5.sleep0", 32'h2012, 1'b1, 8'h54);
        hsleep = 4'b1110;
        step(); clr(); expect_out("t5.alloff", 32'h2012, 1'b0, 8'h00);
        step(); expect_out("t5.idle", 32'h2012, 1'b0, 8'h00);

        // Stall with a block arriving underneath.
        hwake = 4'b1111;
        step(); clr(); expect_out("t6.wake", 32'h2012, 1'b0, 8'h55);
        step(); expect_out("t6.h3", 32'h103, 1'b1, 8'h55);
        sena = 1'b0; hblk = 4'b1000;
        step(); clr(); expect_out("t6.hold0", 32'h103, 1'b1, 8'h95);
        step(); expect_out("t6.hold1", 32'h103, 1'b1, 8'h95);
        step(); expect_out("t6.hold2", 32'h103, 1'b1, 8'h95);
        sena = 1'b1;
        step(); expect_out("t6.h0", 32'h100, 1'b1, 8'h95);
        step(); expect_out("t6.h1", 32'h101, 1'b1, 8'h95);
        step(); expect_out("t6.h2", 32'h102, 1'b1, 8'h95);
        step(); expect_out("t6.skip3", 32'h104, 1'b1, 8'h95);

        // Randomized traffic against the model.
        srst = 1'b1;
        #2 srst = 1'b0;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            sena = ($urandom_range(0, 3) != 0);
            for (int h = 0; h < 4; h++) begin
                hwake[h]  = ($urandom_range(0, 3) == 0);
                hsleep[h] = ($urandom_range(0, 15) == 0);
                hblk[h]   = ($urandom_range(0, 7) == 0);
                hrsm[h]   = ($urandom_range(0, 3) == 0);
            end
            xbra  = ($urandom_range(0, 3) == 0);
            xhart = 2'($urandom_range(0, 3));
            xtgt  = $urandom;
            if (xbra) hblk[xhart] = 1'b0;
            model_step();
            step();
            expect_out("rand", mfpc, mfvld, model_hstat());
        end
        clr();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
